itch_event_streamer: RTL and testbench
======================================

Name: itch_event_streamer

Overview:
- Downstream consumer of the ITCH parser's latched outputs.
- Captures every decoded message into a record FIFO, then serialises each record as one fixed-length AXI-Stream master packet of 11 32-bit beats for DMA to memory.
- Removes the host's dependence on AXI-Lite polling, which only exposes the latest message.
- Sits beside the AXI-Lite register bank, on the parser clock domain.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, stream width; only 32 supported.
- FIFO_DEPTH, 8, record slots; power of two, ≥2.

Ports:
- M_AXIS_ACLK  in  1  parser/stream clock
- M_AXIS_ARESETN  in  1  asynchronous active-low reset
- enable  in  1  capture enable; 0 ignores new messages (not counted as drops)
- latched_valid  in  1  parser message-complete indication
- latched_type  in  4  message type code
- latched_order_ref  in  64  order reference
- latched_side  in  1  buy/sell
- latched_shares  in  32  shares
- latched_price  in  32  price
- latched_new_order_ref  in  64  replace new reference
- latched_timestamp  in  48  timestamp (ns)
- latched_misc_data  in  64  type-specific data
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TDATA  out  32  beat data
- M_AXIS_TKEEP  out  4  always 4'hF while valid
- M_AXIS_TLAST  out  1  last beat of record
- M_AXIS_TREADY  in  1  downstream ready
- fifo_level  out  log2(FIFO_DEPTH)+1  records stored, excluding the record in flight
- drop_count  out  16  records lost to overflow, saturating
- seq_num  out  16  next sequence number to assign

Behaviour:
- Reset is asynchronous:
  - On assertion: all outputs go to 0 immediately; FIFO is emptied; FSM goes to IDLE; seq_num=0; drop_count=0; previous-valid register=0.
  - A record mid-transfer is abandoned with no TLAST; downstream must tolerate this.
- Capture event: cycle where latched_valid=1 and the registered previous latched_valid=0 (rising edge) and enable=1.
  - All fields are sampled that cycle.
  - seq_num is stamped into the record, then incremented by 1 (mod 2^16) on every capture event, including dropped ones. The host detects gaps this way.
- Overflow: capture while FIFO full and no pop in the same cycle → record discarded; drop_count += 1, saturating at 16'hFFFF.
  - Capture while full with a simultaneous pop → capture accepted.
- Record beat layout (beat 0 first):
  - Beat 0: [31:16] seq, [15:5] 0, [4] side, [3:0] type.
  - Beat 1: [31:16] 0, [15:0] ts[47:32].
  - Beat 2: ts[31:0].
  - Beats 3/4: order_ref hi/lo.
  - Beat 5: shares.
  - Beat 6: price.
  - Beats 7/8: new_order_ref hi/lo.
  - Beats 9/10: misc hi/lo.
  - TLAST=1 only on beat 10.
- FSM:
  - IDLE: FIFO non-empty → LOAD.
  - LOAD: pop head into record register; beat counter=0 → SEND.
  - SEND: TVALID=1. On TVALID&TREADY, beat counter +1. Handshake on beat 10 → IDLE.
- Latency:
  - Capture at cycle N; FIFO write at edge ending N.
  - IDLE sees non-empty at N+1; LOAD at N+2; beat 0 valid at N+3.
  - Between back-to-back records, TVALID is low for exactly 2 cycles (IDLE, LOAD).
- AXIS rules:
  - TDATA/TLAST hold stable while TVALID&!TREADY.
  - TVALID never deasserts before handshake.
  - TREADY is not used to form TVALID.
- FIFO pop occurs in LOAD, so the in-flight record frees its slot immediately. Effective buffering is FIFO_DEPTH+1 records.
- fifo_level is updated registered, same cycle as the pointers.
- enable deassertion mid-record does not affect an in-flight or queued record.

Decomposition:
- Package itch_stream_pkg holds:
  - typedef itch_rec_t: packed struct {seq16, type4, side1, ts48, order_ref64, shares32, price32, new_ref64, misc64} = 325 bits.
  - localparams REC_BEATS=11 and BEAT_CNT_W=4.
  - FSM state enum {IDLE, LOAD, SEND}.
- Sub-module itch_rec_fifo: synchronous single-clock FIFO of itch_rec_t.
  - push/pop/full/empty/level.
  - Pointers one bit wider than the address.
  - Same async active-low reset.

Test Plan:
- Single capture (type=4'h1, side=1, order_ref=64'h0123_4567_89AB_CDEF, ts=48'h0000_1234_5678), TREADY=1 → beats 0..10 as laid out, starting 3 cycles after capture. Beat0=32'h0000_0011, TLAST only on beat 10, TKEEP=4'hF.
- latched_valid held high 5 cycles → exactly one record; seq_num 0→1.
- FIFO_DEPTH=8, TREADY=0, 12 captures → 9 records retained (8 queued + 1 loaded), drop_count=3, seq_num=12. Releasing TREADY yields seqs 0..8, contiguous.
- Random TREADY toggling across 4 records → TDATA/TLAST stable during stalls; each record has 11 beats; 2-cycle TVALID gap between records.
- Full FIFO with a capture coinciding with the LOAD pop → record accepted, drop_count unchanged.
- Reset asserted mid-record at beat 5 → TVALID=0 asynchronously. After release: seq_num=0, fifo_level=0, next capture emits seq 0.

Source files
------------

// File: rtl/itch_stream_pkg.sv
// rtl/itch_stream_pkg.sv - shared record type, beat layout and FSM states for the ITCH event streamer
package itch_stream_pkg;

   localparam int REC_BEATS  = 11;
   localparam int BEAT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0] seq;
      logic [3:0]  msg_type;
      logic        side;
      logic [47:0] ts;
      logic [63:0] order_ref;
      logic [31:0] shares;
      logic [31:0] price;
      logic [63:0] new_ref;
      logic [63:0] misc;
   } itch_rec_t;

   // Maps a beat index onto the 32-bit word carried by that beat.
   function automatic logic [31:0] rec_beat(input itch_rec_t rec, input logic [BEAT_CNT_W-1:0] idx);
      logic [31:0] w;
      w = '0;
      case (idx)
         4'd0:    w = {rec.seq, 11'd0, rec.side, rec.msg_type};
         4'd1:    w = {16'd0, rec.ts[47:32]};
         4'd2:    w = rec.ts[31:0];
         4'd3:    w = rec.order_ref[63:32];
         4'd4:    w = rec.order_ref[31:0];
         4'd5:    w = rec.shares;
         4'd6:    w = rec.price;
         4'd7:    w = rec.new_ref[63:32];
         4'd8:    w = rec.new_ref[31:0];
         4'd9:    w = rec.misc[63:32];
         4'd10:   w = rec.misc[31:0];
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/itch_rec_fifo.sv
// rtl/itch_rec_fifo.sv - single-clock record FIFO of itch_rec_t
// Ports: clk_i, rst_ni (async, active low); push_i/wdata_i write side;
//        pop_i/rdata_o read side (rdata_o shows the head); full_o, empty_o, level_o status.
module itch_rec_fifo
   import itch_stream_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  itch_rec_t                wdata_i,
   input  logic                     pop_i,
   output itch_rec_t                rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;

   itch_rec_t   mem [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q, level_q;
   logic        do_push, do_pop;

   // Extra pointer MSB tells full from empty when the address bits match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem[rd_ptr_q[AW-1:0]];
   assign level_o = level_q;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + ONE;
         if (do_push && !do_pop)      level_q <= level_q + ONE;
         else if (do_pop && !do_push) level_q <= level_q - ONE;
      end
   end

endmodule

// File: rtl/itch_event_streamer.sv
// rtl/itch_event_streamer.sv - captures parser messages into a FIFO and streams each as an 11-beat AXI-Stream packet
// Ports: M_AXIS_ACLK/M_AXIS_ARESETN clock and async active-low reset; enable gates capture;
//        latched_* parser outputs; M_AXIS_T* stream master; fifo_level, drop_count, seq_num status.
module itch_event_streamer
   import itch_stream_pkg::*;
#(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH           = 8
)
(
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESETN,
   input  logic                              enable,
   input  logic                              latched_valid,
   input  logic [3:0]                        latched_type,
   input  logic [63:0]                       latched_order_ref,
   input  logic                              latched_side,
   input  logic [31:0]                       latched_shares,
   input  logic [31:0]                       latched_price,
   input  logic [63:0]                       latched_new_order_ref,
   input  logic [47:0]                       latched_timestamp,
   input  logic [63:0]                       latched_misc_data,
   output logic                              M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
   output logic [15:0]                       drop_count,
   output logic [15:0]                       seq_num
);

   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(REC_BEATS - 1);
   localparam logic [BEAT_CNT_W-1:0] BEAT_ONE  = 1;

   state_t                  state_q, state_d;
   logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
   itch_rec_t               rec_q, rec_d, cap_rec, fifo_head;
   logic                    prev_valid_q;
   logic [15:0]             seq_q, drop_q;
   logic                    capture, pop, overflow, fifo_full, fifo_empty;

   // Only the rising edge of latched_valid is a new message.
   assign capture  = latched_valid && !prev_valid_q && enable;
   assign pop      = (state_q == LOAD);
   assign overflow = capture && fifo_full && !pop;

   assign cap_rec = '{seq:       seq_q,
                      msg_type:  latched_type,
                      side:      latched_side,
                      ts:        latched_timestamp,
                      order_ref: latched_order_ref,
                      shares:    latched_shares,
                      price:     latched_price,
                      new_ref:   latched_new_order_ref,
                      misc:      latched_misc_data};

   itch_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (M_AXIS_ACLK),
      .rst_ni  (M_AXIS_ARESETN),
      .push_i  (capture),
      .wdata_i (cap_rec),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      rec_d   = rec_q;
      case (state_q)
         IDLE: if (!fifo_empty) state_d = LOAD;
         LOAD: begin
            rec_d   = fifo_head;
            beat_d  = '0;
            state_d = SEND;
         end
         SEND: if (M_AXIS_TREADY) begin
            if (beat_q == LAST_BEAT) state_d = IDLE;
            else                     beat_d  = beat_q + BEAT_ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         rec_q        <= '0;
         prev_valid_q <= 1'b0;
         seq_q        <= '0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         rec_q        <= rec_d;
         prev_valid_q <= latched_valid;
         // Dropped captures still consume a number so the host can see the gap.
         if (capture) seq_q <= seq_q + 16'd1;
         if (overflow && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
   end

   // Outputs derive only from reset registers, so they read zero while in reset.
   assign M_AXIS_TVALID = (state_q == SEND);
   assign M_AXIS_TDATA  = M_AXIS_TVALID ? rec_beat(rec_q, beat_q) : '0;
   assign M_AXIS_TKEEP  = M_AXIS_TVALID ? '1 : '0;
   assign M_AXIS_TLAST  = M_AXIS_TVALID && (beat_q == LAST_BEAT);
   assign drop_count    = drop_q;
   assign seq_num       = seq_q;

endmodule

// File: tb/tb_itch_event_streamer.sv
// tb/tb_itch_event_streamer.sv - self-checking bench for itch_event_streamer
module tb_itch_event_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        latched_valid = 1'b0;
   logic [3:0]  latched_type = '0;
   logic [63:0] latched_order_ref = '0;
   logic        latched_side = 1'b0;
   logic [31:0] latched_shares = '0;
   logic [31:0] latched_price = '0;
   logic [63:0] latched_new_order_ref = '0;
   logic [47:0] latched_timestamp = '0;
   logic [63:0] latched_misc_data = '0;
   logic        tvalid, tlast;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tready = 1'b0;
   logic [3:0]  fifo_level;
   logic [15:0] drop_count, seq_num;

   itch_event_streamer #(.C_M_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
      .M_AXIS_ACLK           (clk),
      .M_AXIS_ARESETN        (rst_n),
      .enable                (enable),
      .latched_valid         (latched_valid),
      .latched_type          (latched_type),
      .latched_order_ref     (latched_order_ref),
      .latched_side          (latched_side),
      .latched_shares        (latched_shares),
      .latched_price         (latched_price),
      .latched_new_order_ref (latched_new_order_ref),
      .latched_timestamp     (latched_timestamp),
      .latched_misc_data     (latched_misc_data),
      .M_AXIS_TVALID         (tvalid),
      .M_AXIS_TDATA          (tdata),
      .M_AXIS_TKEEP          (tkeep),
      .M_AXIS_TLAST          (tlast),
      .M_AXIS_TREADY         (tready),
      .fifo_level            (fifo_level),
      .drop_count            (drop_count),
      .seq_num               (seq_num)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit [3:0]  typ;
      bit        side;
      bit [47:0] ts;
      bit [63:0] oref;
      bit [31:0] shares;
      bit [31:0] price;
      bit [63:0] nref;
      bit [63:0] misc;
   } tb_msg_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   tb_msg_t     exp_msg [int];
   int          model_seq, n_caps, rx_count, last_seq;
   int          rx_seq [$];
   bit [31:0]   rx_words [11];
   bit [31:0]   last_words [11];
   int          rx_idx = 0;
   int          ready_mode = 0;
   int          cap_cyc = 0, rise_cyc = 0;
   bit          prev_tv = 0, hold_v = 0, hold_l = 0, in_gap = 0, gap_exp = 0;
   bit [31:0]   hold_d = 0;
   int          gap_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] exp_word(input tb_msg_t m, input int seq, input int i);
      bit [15:0] s;
      s = seq[15:0];
      case (i)
         0:  return {s, 11'd0, m.side, m.typ};
         1:  return {16'd0, m.ts[47:32]};
         2:  return m.ts[31:0];
         3:  return m.oref[63:32];
         4:  return m.oref[31:0];
         5:  return m.shares;
         6:  return m.price;
         7:  return m.nref[63:32];
         8:  return m.nref[31:0];
         9:  return m.misc[63:32];
         default: return m.misc[31:0];
      endcase
   endfunction

   function automatic tb_msg_t rand_msg();
      tb_msg_t m;
      m.typ    = 4'($urandom);
      m.side   = 1'($urandom);
      m.ts     = {16'($urandom), $urandom};
      m.oref   = {$urandom, $urandom};
      m.shares = $urandom;
      m.price  = $urandom;
      m.nref   = {$urandom, $urandom};
      m.misc   = {$urandom, $urandom};
      return m;
   endfunction

   task automatic model_clear();
      exp_msg.delete();
      rx_seq.delete();
      model_seq = 0;
      n_caps    = 0;
      rx_count  = 0;
      last_seq  = -1;
   endtask

   task automatic finish_record();
      int s;
      int n;
      s = int'(rx_words[0][31:16]);
      n = (rx_idx < 11) ? rx_idx : 11;
      check_eq("beat_count", rx_idx, 11);
      check_eq("seq_known", exp_msg.exists(s), 1);
      check_eq("seq_order", s > last_seq, 1);
      if (exp_msg.exists(s))
         for (int i = 0; i < n; i++)
            check_eq($sformatf("beat%0d_seq%0d", i, s), rx_words[i], exp_word(exp_msg[s], s, i));
      last_seq = s;
      rx_seq.push_back(s);
      rx_count++;
      last_words = rx_words;
      rx_idx = 0;
   endtask

   // Stream monitor: runs on the falling edge, where the upcoming handshake is already decided.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         rx_idx = 0; hold_v = 0; in_gap = 0; prev_tv = 0;
         continue;
      end
      if (tvalid && !prev_tv) rise_cyc = cyc;
      if (hold_v) begin
         check_eq("stall_valid", tvalid, 1);
         check_eq("stall_data", tdata, hold_d);
         check_eq("stall_last", tlast, hold_l);
      end
      hold_v = tvalid && !tready;
      hold_d = tdata;
      hold_l = tlast;
      if (in_gap) begin
         if (!tvalid) gap_cnt++;
         else begin
            if (gap_exp) check_eq("gap_cycles", gap_cnt, 2);
            in_gap = 0;
         end
      end
      if (tvalid && tready) begin
         check_eq("tkeep", tkeep, 4'hF);
         check_eq("tlast_pos", tlast, rx_idx == 10);
         if (rx_idx < 11) rx_words[rx_idx] = tdata;
         rx_idx++;
         if (tlast) begin
            finish_record();
            in_gap  = 1;
            gap_cnt = 0;
            gap_exp = (fifo_level != 0);
         end
      end
      prev_tv = tvalid;
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       tready = 1'b0;
         1:       tready = 1'b1;
         default: tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Caller is just past a rising edge; the message is presented from here for hold cycles.
   task automatic send_now(input tb_msg_t m, input int hold, input bit en);
      latched_type          = m.typ;
      latched_side          = m.side;
      latched_timestamp     = m.ts;
      latched_order_ref     = m.oref;
      latched_shares        = m.shares;
      latched_price         = m.price;
      latched_new_order_ref = m.nref;
      latched_misc_data     = m.misc;
      enable                = en;
      latched_valid         = 1'b1;
      cap_cyc               = cyc;
      if (en) begin
         exp_msg[model_seq] = m;
         model_seq = (model_seq + 1) % 65536;
         n_caps++;
      end
      repeat (hold) @(posedge clk);
      #1;
      latched_valid = 1'b0;
      enable        = 1'b1;
   endtask

   task automatic send_msg(input tb_msg_t m, input int hold, input bit en);
      @(posedge clk);
      #1;
      send_now(m, hold, en);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      int quiet;
      int n;
      quiet = 0;
      n = 0;
      while (quiet < 4 && n < 3000) begin
         @(negedge clk);
         n++;
         if (!tvalid && fifo_level == 0) quiet++;
         else quiet = 0;
      end
      check_eq({tag, "_drain"}, quiet >= 4, 1);
   endtask

   initial begin
      tb_msg_t m;
      int n;
      model_clear();

      // Reset state
      #3;
      check_eq("rst_tvalid", tvalid, 0);
      check_eq("rst_tdata", tdata, 0);
      check_eq("rst_tlast", tlast, 0);
      check_eq("rst_tkeep", tkeep, 0);
      check_eq("rst_level", fifo_level, 0);
      check_eq("rst_drops", drop_count, 0);
      check_eq("rst_seq", seq_num, 0);
      #19;
      rst_n = 1'b1;

      // Single capture, valid held 5 cycles
      ready_mode = 1;
      m.typ = 4'h1; m.side = 1'b1; m.ts = 48'h0000_1234_5678;
      m.oref = 64'h0123_4567_89AB_CDEF; m.shares = 32'd100; m.price = 32'd12345;
      m.nref = 64'h0; m.misc = 64'hDEAD_BEEF_0000_0001;
      send_msg(m, 5, 1'b1);
      drain("single");
      check_eq("single_latency", rise_cyc - cap_cyc, 3);
      check_eq("single_count", rx_count, 1);
      check_eq("single_seq_num", seq_num, 1);
      check_eq("single_beat0", last_words[0], 32'h0000_0011);
      check_eq("single_beat1", last_words[1], 32'h0000_0000);
      check_eq("single_beat2", last_words[2], 32'h1234_5678);
      check_eq("single_beat3", last_words[3], 32'h0123_4567);
      check_eq("single_beat4", last_words[4], 32'h89AB_CDEF);
      send_msg(rand_msg(), 1, 1'b0);
      drain("disabled");
      check_eq("disabled_seq_num", seq_num, 1);
      check_eq("disabled_count", rx_count, 1);

      // Overflow: 12 captures against a stalled sink
      do_reset();
      ready_mode = 0;
      for (int i = 0; i < 12; i++) send_msg(rand_msg(), 1, 1'b1);
      check_eq("ovf_level", fifo_level, 8);
      check_eq("ovf_drops", drop_count, 3);
      check_eq("ovf_seq_num", seq_num, 12);
      ready_mode = 1;
      drain("ovf");
      check_eq("ovf_count", rx_count, 9);
      for (int i = 0; i < rx_seq.size(); i++) check_eq($sformatf("ovf_rx_seq%0d", i), rx_seq[i], i);

      // Capture into a full FIFO in the same cycle as the LOAD pop
      do_reset();
      ready_mode = 0;
      for (int i = 0; i < 9; i++) send_msg(rand_msg(), 1, 1'b1);
      check_eq("load_pre_level", fifo_level, 8);
      ready_mode = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(tvalid && tready && tlast) && n < 200);
      check_eq("load_wait", n < 200, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("load_full", fifo_level, 8);
      send_now(rand_msg(), 1, 1'b1);
      check_eq("load_drops", drop_count, 0);
      check_eq("load_level", fifo_level, 8);
      check_eq("load_seq_num", seq_num, 10);
      drain("load");
      check_eq("load_count", rx_count, 10);
      if (rx_seq.size() == 10) check_eq("load_last_seq", rx_seq[9], 9);

      // Random back-pressure across 4 queued records
      do_reset();
      ready_mode = 0;
      for (int i = 0; i < 4; i++) send_msg(rand_msg(), 1, 1'b1);
      ready_mode = 2;
      drain("stall");
      check_eq("stall_count", rx_count, 4);

      // Reset in the middle of a record
      do_reset();
      ready_mode = 1;
      for (int i = 0; i < 3; i++) send_msg(rand_msg(), 1, 1'b1);
      n = 0;
      while (rx_idx != 6 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("mid_wait", n < 200, 1);
      #1;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_eq("mid_tvalid", tvalid, 0);
      check_eq("mid_tlast", tlast, 0);
      check_eq("mid_tdata", tdata, 0);
      check_eq("mid_level", fifo_level, 0);
      check_eq("mid_seq_num", seq_num, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      send_msg(rand_msg(), 1, 1'b1);
      drain("mid");
      check_eq("mid_count", rx_count, 1);
      if (rx_seq.size() == 1) check_eq("mid_first_seq", rx_seq[0], 0);

      // Randomised traffic with random enable, hold and back-pressure
      do_reset();
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 12)) @(posedge clk);
         send_msg(rand_msg(), $urandom_range(1, 3), $urandom_range(0, 9) != 0);
      end
      drain("rand");
      check_eq("rand_seq_num", seq_num, model_seq);
      check_eq("rand_drops", drop_count, n_caps - rx_count);
      check_eq("rand_level", fifo_level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
